// File: rtl/uart_program_loader.sv
// uart_program_loader
// Receives a program image over an 8N1 UART link and writes it into
// instruction memory one 32-bit little-endian word at a time.
// Stream layout: a 4-byte little-endian size field, then the payload bytes.
// Optional feature: define LOADER_CHECKSUM_EN to require one trailing byte
// equal to the XOR of every payload byte.
module uart_program_loader #(
    parameter int CLK_PER_HALF_BIT = 5208,
    parameter int MAX_BYTES        = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int              CNT_W     = $clog2(2 * CLK_PER_HALF_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(2 * CLK_PER_HALF_BIT - 1);
    localparam logic [31:0]      MAX_SIZE  = 32'(MAX_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rxState_t;

    typedef enum logic [1:0] {
        L_SIZE,
        L_DATA,
        L_DONE,
        L_ERR
    } ldState_t;

    // Synchronizer flops
    logic rxdMeta_q;
    logic rxdSync_q;

    // UART receiver state
    rxState_t         rxState_q, rxState_d;
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byteValid;
    logic             frameErr;
    logic             startAccept;

    // Loader state
    ldState_t    ldState_q, ldState_d;
    logic [1:0]  sizeIdx_q, sizeIdx_d;
    logic [31:0] size_q, size_d;
    logic [31:0] byteCount_q, byteCount_d;
    logic [31:0] word_q, word_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        loadActive;
    logic [7:0]  rxByte;
    logic [31:0] newSize;
    logic [31:0] wordNext;

    assign loadActive = (ldState_q == L_SIZE) || (ldState_q == L_DATA);
    assign rxByte     = shift_q;
    assign newSize    = {rxByte, size_q[23:0]};

    // Two-flop synchronizer so the asynchronous serial line never feeds logic directly
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxdMeta_q <= 1'b1;
            rxdSync_q <= 1'b1;
        end else begin
            rxdMeta_q <= rxd;
            rxdSync_q <= rxdMeta_q;
        end
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxState_q <= IDLE;
            bitCnt_q  <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
        end else begin
            rxState_q <= rxState_d;
            bitCnt_q  <= bitCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
        end
    end

    // Receiver next state: confirm start at half bit, then sample every full bit at mid-bit
    always_comb begin
        rxState_d   = rxState_q;
        bitCnt_d    = bitCnt_q + 1'b1;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        byteValid   = 1'b0;
        frameErr    = 1'b0;
        startAccept = 1'b0;
        case (rxState_q)
            IDLE: begin
                bitCnt_d = '0;
                if (!rxdSync_q && loadActive) begin
                    rxState_d = START;
                end
            end
            START: begin
                if (bitCnt_q == HALF_LAST) begin
                    bitCnt_d = '0;
                    if (!rxdSync_q) begin
                        rxState_d   = DATA;
                        bitIdx_d    = '0;
                        startAccept = 1'b1;
                    end else begin
                        rxState_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (bitCnt_q == FULL_LAST) begin
                    bitCnt_d = '0;
                    shift_d  = {rxdSync_q, shift_q[7:1]};
                    if (bitIdx_q == 3'd7) begin
                        rxState_d = STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bitCnt_q == FULL_LAST) begin
                    bitCnt_d  = '0;
                    rxState_d = IDLE;
                    if (rxdSync_q) begin
                        byteValid = 1'b1;
                    end else begin
                        frameErr = 1'b1;
                    end
                end
            end
            default: begin
                rxState_d = IDLE;
            end
        endcase
    end

    // Loader state register and registered memory-write outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            ldState_q   <= L_SIZE;
            sizeIdx_q   <= '0;
            size_q      <= '0;
            byteCount_q <= '0;
            word_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            ldState_q   <= ldState_d;
            sizeIdx_q   <= sizeIdx_d;
            size_q      <= size_d;
            byteCount_q <= byteCount_d;
            word_q      <= word_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // Loader next state: collect size, pack payload into words, finish or fail
    always_comb begin
        ldState_d   = ldState_q;
        sizeIdx_d   = sizeIdx_q;
        size_d      = size_q;
        byteCount_d = byteCount_q;
        word_d      = word_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        wordNext    = word_q | ({24'b0, rxByte} << {byteCount_q[1:0], 3'b000});
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (ldState_q)
            L_SIZE: begin
                if (frameErr) begin
                    ldState_d = L_ERR;
                end else if (byteValid) begin
                    size_d[{sizeIdx_q, 3'b000} +: 8] = rxByte;
                    sizeIdx_d = sizeIdx_q + 2'd1;
                    if (sizeIdx_q == 2'd3) begin
                        if (newSize == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            ldState_d = L_DATA;
`else
                            ldState_d = L_DONE;
`endif
                        end else if (newSize > MAX_SIZE) begin
                            ldState_d = L_ERR;
                        end else begin
                            ldState_d = L_DATA;
                        end
                    end
                end
            end
            L_DATA: begin
                if (frameErr) begin
                    ldState_d = L_ERR;
                end else if (byteValid && (byteCount_q != size_q)) begin
                    byteCount_d = byteCount_q + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rxByte;
`endif
                    if ((byteCount_q[1:0] == 2'd3) || ((byteCount_q + 32'd1) == size_q)) begin
                        we_d    = 1'b1;
                        addr_d  = {byteCount_q[31:2], 2'b00};
                        wdata_d = wordNext;
                        word_d  = '0;
                    end else begin
                        word_d = wordNext;
                    end
`ifdef LOADER_CHECKSUM_EN
                end else if (byteValid) begin
                    ldState_d = (rxByte == csum_q) ? L_DONE : L_ERR;
`else
                end else if (we_q && (byteCount_q == size_q)) begin
                    ldState_d = L_DONE;
`endif
                end
            end
            default: begin
                ldState_d = ldState_q;
            end
        endcase
        if (startAccept) begin
            busy_d = 1'b1;
        end
        if ((ldState_d == L_DONE) || (ldState_d == L_ERR)) begin
            busy_d = 1'b0;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = (ldState_q == L_DONE);
    assign err        = (ldState_q == L_ERR);

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader
// Directed bench for uart_program_loader with a fast bit clock
// (CLK_PER_HALF_BIT = 4, so one UART bit lasts 8 clk cycles).
// Honours LOADER_CHECKSUM_EN by appending the XOR byte to each load.
module tb_uart_program_loader;

    localparam int BIT_CYC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int vectorCount = 0;
    int missCount   = 0;

    int          weCount = 0;
    logic [31:0] wrAddr[64];
    logic [31:0] wrData[64];
    int          cycleNum      = 0;
    int          lastWeCycle   = 0;
    int          doneRiseCycle = 0;
    logic        donePrev      = 1'b0;

    logic [7:0] txQueue[$];
    int         base;

    always #5 clk = ~clk;

    uart_program_loader #(
        .CLK_PER_HALF_BIT(4),
        .MAX_BYTES(65536)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .busy(busy),
        .done(done),
        .err(err)
    );

    // Record every write strobe and the cycle done rises, sampled away from the active edge
    always @(negedge clk) begin
        cycleNum = cycleNum + 1;
        if (imem_we) begin
            if (weCount < 64) begin
                wrAddr[weCount] = imem_addr;
                wrData[weCount] = imem_wdata;
            end
            weCount     = weCount + 1;
            lastWeCycle = cycleNum;
        end
        if (done && !donePrev) begin
            doneRiseCycle = cycleNum;
        end
        donePrev = done;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount = vectorCount + 1;
        if (observed !== expected) begin
            missCount = missCount + 1;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        rxd = 1'b0;
        waitCycles(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            waitCycles(BIT_CYC);
        end
        rxd = stopBit;
        waitCycles(BIT_CYC);
        rxd = 1'b1;
        waitCycles(2 * BIT_CYC);
    endtask

    task automatic sendQueue();
        for (int i = 0; i < txQueue.size(); i++) begin
            applyStimulus(txQueue[i], 1'b1);
        end
    endtask

    task automatic doReset();
        rst = 1'b0;
        rxd = 1'b1;
        waitCycles(4);
        rst = 1'b1;
        waitCycles(2);
    endtask

    initial begin
        rst = 1'b0;
        rxd = 1'b1;
        waitCycles(4);

        // Reset state
        checkOutput("reset imem_we", 32'(imem_we), 32'd0);
        checkOutput("reset imem_addr", imem_addr, 32'd0);
        checkOutput("reset imem_wdata", imem_wdata, 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        rst = 1'b1;
        waitCycles(2);

        // Size 8, two full words
        base = weCount;
        txQueue = '{8'h08, 8'h00, 8'h00, 8'h00};
        sendQueue();
        checkOutput("t1 busy mid-load", 32'(busy), 32'd1);
        txQueue = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        txQueue.push_back(8'h90);
`endif
        sendQueue();
        waitCycles(4);
        checkOutput("t1 write count", 32'(weCount - base), 32'd2);
        checkOutput("t1 addr0", wrAddr[base], 32'h0000_0000);
        checkOutput("t1 data0", wrData[base], 32'h0000_0513);
        checkOutput("t1 addr1", wrAddr[base+1], 32'h0000_0004);
        checkOutput("t1 data1", wrData[base+1], 32'h0010_0593);
        checkOutput("t1 done", 32'(done), 32'd1);
        checkOutput("t1 err", 32'(err), 32'd0);
        checkOutput("t1 busy", 32'(busy), 32'd0);
        checkOutput("t1 addr held", imem_addr, 32'h0000_0004);
        checkOutput("t1 wdata held", imem_wdata, 32'h0010_0593);
`ifndef LOADER_CHECKSUM_EN
        checkOutput("t1 done one cycle after write", 32'(doneRiseCycle - lastWeCycle), 32'd1);
`endif
        applyStimulus(8'h55, 1'b1);
        checkOutput("t1 ignored traffic writes", 32'(weCount - base), 32'd2);
        checkOutput("t1 ignored traffic done", 32'(done), 32'd1);
        checkOutput("t1 ignored traffic wdata", imem_wdata, 32'h0010_0593);

        // Size 5, partial last word
        doReset();
        base = weCount;
        txQueue = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
`ifdef LOADER_CHECKSUM_EN
        txQueue.push_back(8'hEE);
`endif
        sendQueue();
        waitCycles(4);
        checkOutput("t2 write count", 32'(weCount - base), 32'd2);
        checkOutput("t2 addr0", wrAddr[base], 32'h0000_0000);
        checkOutput("t2 data0", wrData[base], 32'hDDCC_BBAA);
        checkOutput("t2 addr1", wrAddr[base+1], 32'h0000_0004);
        checkOutput("t2 data1", wrData[base+1], 32'h0000_00EE);
        checkOutput("t2 done", 32'(done), 32'd1);
        checkOutput("t2 err", 32'(err), 32'd0);

        // Size 0, no writes
        doReset();
        base = weCount;
        txQueue = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        txQueue.push_back(8'h00);
`endif
        sendQueue();
        checkOutput("t3 write count", 32'(weCount - base), 32'd0);
        checkOutput("t3 done", 32'(done), 32'd1);
        checkOutput("t3 err", 32'(err), 32'd0);
        checkOutput("t3 busy", 32'(busy), 32'd0);

        // Oversize load
        doReset();
        base = weCount;
        txQueue = '{8'h01, 8'h00, 8'h01, 8'h00};
        sendQueue();
        waitCycles(4);
        checkOutput("t4 write count", 32'(weCount - base), 32'd0);
        checkOutput("t4 err", 32'(err), 32'd1);
        checkOutput("t4 done", 32'(done), 32'd0);
        checkOutput("t4 busy", 32'(busy), 32'd0);

        // One-cycle glitch, then a framing error
        doReset();
        base = weCount;
        rxd = 1'b0;
        waitCycles(1);
        rxd = 1'b1;
        waitCycles(3 * BIT_CYC);
        checkOutput("t5 glitch busy", 32'(busy), 32'd0);
        checkOutput("t5 glitch err", 32'(err), 32'd0);
        applyStimulus(8'hA5, 1'b0);
        checkOutput("t5 framing err", 32'(err), 32'd1);
        checkOutput("t5 framing done", 32'(done), 32'd0);
        checkOutput("t5 framing busy", 32'(busy), 32'd0);
        checkOutput("t5 write count", 32'(weCount - base), 32'd0);

        // Reset in the middle of a payload, then a clean 4-byte load
        doReset();
        base = weCount;
        txQueue = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02};
        sendQueue();
        checkOutput("t6 busy before abort", 32'(busy), 32'd1);
        rst = 1'b0;
        waitCycles(3);
        checkOutput("t6 abort busy", 32'(busy), 32'd0);
        checkOutput("t6 abort wdata", imem_wdata, 32'd0);
        rst = 1'b1;
        waitCycles(2);
        checkOutput("t6 abort writes", 32'(weCount - base), 32'd0);
        txQueue = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
`ifdef LOADER_CHECKSUM_EN
        txQueue.push_back(8'h04);
`endif
        sendQueue();
        waitCycles(4);
        checkOutput("t6 write count", 32'(weCount - base), 32'd1);
        checkOutput("t6 addr0", wrAddr[base], 32'h0000_0000);
        checkOutput("t6 data0", wrData[base], 32'h0403_0201);
        checkOutput("t6 done", 32'(done), 32'd1);
        checkOutput("t6 err", 32'(err), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: word still written, load fails
        doReset();
        base = weCount;
        txQueue = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        sendQueue();
        waitCycles(4);
        checkOutput("t7 write count", 32'(weCount - base), 32'd1);
        checkOutput("t7 err", 32'(err), 32'd1);
        checkOutput("t7 done", 32'(done), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

Interface
REQ-001 The block SHALL have parameter CLK_PER_HALF_BIT, default 5208, giving clk cycles per half UART bit (100 MHz clk, 9600 bps).
REQ-002 The block SHALL have parameter MAX_BYTES, default 65536, giving the largest accepted program size in bytes.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port rxd, input, 1 bit: UART serial in, 8N1, LSB first, idle high.
REQ-006 The block SHALL have port imem_we, output, 1 bit: instruction-memory write strobe, one-cycle pulse.
REQ-007 The block SHALL have port imem_addr, output, 32 bits: byte address, word-aligned.
REQ-008 The block SHALL have port imem_wdata, output, 32 bits: write data, little-endian packed.
REQ-009 The block SHALL have port busy, output, 1 bit: load in progress.
REQ-010 The block SHALL have port done, output, 1 bit: load complete, sticky.
REQ-011 The block SHALL have port err, output, 1 bit: load failed, sticky.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer before any use.
REQ-013 RX FSM states SHALL be IDLE, START, DATA and STOP.
REQ-014 In IDLE, a low synchronized rxd SHALL move the FSM to START.
REQ-015 In START, after CLK_PER_HALF_BIT cycles, rxd still low SHALL move to DATA and rxd high SHALL return to IDLE (glitch).
REQ-016 DATA SHALL sample 8 bits, each 2*CLK_PER_HALF_BIT cycles apart at mid-bit, LSB first.
REQ-017 STOP SHALL sample at mid-bit; stop=1 SHALL emit an internal byte_valid pulse for 1 cycle; stop=0 SHALL discard the byte and set err.
REQ-018 Loader FSM states SHALL be L_SIZE, L_DATA, L_DONE and L_ERR.
REQ-019 In L_SIZE, the first 4 bytes SHALL form a 32-bit size, little-endian (byte 0 = bits 7:0).
REQ-020 Size 0 SHALL go directly to L_DONE with no writes.
REQ-021 Size > MAX_BYTES SHALL go to L_ERR with no writes.
REQ-022 In L_DATA, payload bytes SHALL be packed little-endian into a word: byte k of the word goes to bits 8k+7:8k.
REQ-023 When a word's 4th byte arrives, imem_we SHALL pulse on the cycle after that byte_valid, with imem_addr = 4*word_index, where word_index starts at 0.
REQ-024 When the final byte arrives in a partial word, that word SHALL be written the same way with its unfilled upper bytes zero.
REQ-025 After the final write, the FSM SHALL enter L_DONE one cycle later, and done SHALL rise.
REQ-026 busy SHALL be 1 from the first START acceptance until L_DONE or L_ERR is reached.
REQ-027 In L_DONE and L_ERR, all further rxd traffic SHALL be ignored, with no writes and no output changes, until reset.
REQ-028 err and done SHALL never both be 1.
REQ-029 A framing error during a load SHALL move the FSM to L_ERR.
REQ-030 imem_addr and imem_wdata SHALL hold their last written values between strobes.

Reset
REQ-031 With rst=0 at a clk edge, all outputs SHALL be 0, both FSMs SHALL be idle (IDLE, L_SIZE), and all counters and the assembly word SHALL be cleared.
REQ-032 A reset during a load SHALL abort it immediately: no pending partial word is written, and the next load starts from the size field.

Configuration
REQ-033 With LOADER_CHECKSUM_EN defined, the block SHALL expect one extra byte after the payload equal to the XOR of all payload bytes.
REQ-034 With LOADER_CHECKSUM_EN defined, a checksum match SHALL give L_DONE and a mismatch SHALL give L_ERR; already-written words are not retracted.
REQ-035 With LOADER_CHECKSUM_EN defined and size 0, the checksum byte SHALL be 0x00.
REQ-036 Without LOADER_CHECKSUM_EN, no checksum byte SHALL be consumed and no checksum logic SHALL exist.

Verification
REQ-037 Bench SHALL use CLK_PER_HALF_BIT=4 and apply: size 8 (08 00 00 00), payload 13 05 00 00 93 05 10 00 -> writes (0x0,0x00000513), (0x4,0x00100593), then done=1, err=0, busy=0.
REQ-038 Bench SHALL apply: size 5, payload AA BB CC DD EE -> writes (0x0,0xDDCCBBAA), (0x4,0x000000EE), then done=1.
REQ-039 Bench SHALL apply: size 0 -> no imem_we, done=1 after the 4th size byte.
REQ-040 Bench SHALL apply: size 0x00010001 with MAX_BYTES=65536 -> err=1, no imem_we.
REQ-041 Bench SHALL apply: 1-cycle low glitch on idle rxd, then a byte with stop bit 0 -> glitch ignored, then err=1.
REQ-042 Bench SHALL apply: rst low mid-payload, then size 4 with 01 02 03 04 -> single write (0x0,0x04030201), done=1; with LOADER_CHECKSUM_EN, checksum 0x04 -> done, checksum 0x05 -> err.
